// File: rtl/axis_packet_fifo_pkg.sv
// rtl/axis_packet_fifo_pkg.sv - shared types and default sizes for the RX packet FIFO
package axis_pkt_fifo_pkg;

  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_ADDR_WIDTH    = 9;
  localparam int DEF_PKT_CNT_WIDTH = 8;

  // Write-side frame state: receiving a frame, or swallowing the rest of an overflowed one
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECV    = 2'd1,
    DISCARD = 2'd2
  } wr_state_e;

endpackage

// File: rtl/axis_packet_fifo_if.sv
// rtl/axis_packet_fifo_if.sv - AXI-Stream beat bundle with master/slave views
interface axis_packet_fifo_if
  import axis_pkt_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/axis_packet_fifo_sdp_ram.sv
// rtl/axis_packet_fifo_sdp_ram.sv - simple dual-port RAM, one write port, one registered read port
module sdp_ram #(
  parameter int WIDTH      = 33,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage array is not reset; read data holds when re is low so the reader can stall
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axis_packet_fifo.sv
// rtl/axis_packet_fifo.sv - store-and-forward AXI-Stream packet FIFO; drop counter under AXIS_PKT_FIFO_STATS_EN
module axis_packet_fifo
  import axis_pkt_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int PKT_CNT_WIDTH = DEF_PKT_CNT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  axis_packet_fifo_if.slave        s_axis,
  input  logic                     i_frame_drop,
  axis_packet_fifo_if.master       m_axis,
  output logic [ADDR_WIDTH:0]      o_wr_cnt,
  output logic [PKT_CNT_WIDTH-1:0] o_pkt_cnt,
  output logic                     o_drop,
  output logic [15:0]              o_drop_cnt
);

  localparam int                       PW      = ADDR_WIDTH + 1;
  localparam logic [PW-1:0]            DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [PW-1:0]            PTR_ONE = PW'(1);
  localparam logic [PKT_CNT_WIDTH-1:0] CNT_ONE = PKT_CNT_WIDTH'(1);
  localparam logic [PKT_CNT_WIDTH-1:0] CNT_MAX = {PKT_CNT_WIDTH{1'b1}};

  wr_state_e state_q, state_d;
  logic [PW-1:0] wr_spec_q, wr_spec_d;
  logic [PW-1:0] wr_commit_q, wr_commit_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          s_tready_q;
  logic          drop_q, drop_d;
  logic [PKT_CNT_WIDTH-1:0] pkt_cnt_q, pkt_cnt_d;
  logic          ram_vld_q, ram_vld_d;
  logic          out_vld_q, out_vld_d;
  logic          out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

  logic [PW-1:0]         used;
  logic                  full, beat_acc, discard_beat, wr_en, eof, commit;
  logic                  out_load, rd_en, out_last_fire;
  logic [DATA_WIDTH:0]   ram_rdata;

  // Full is judged on registered pointers only; a same-cycle read does not rescue the beat
  assign used         = wr_spec_q - rd_ptr_q;
  assign full         = (used == DEPTH);
  assign beat_acc     = s_axis.tvalid & s_tready_q;
  assign discard_beat = full | (state_q == DISCARD);
  assign wr_en        = beat_acc & ~discard_beat;
  assign eof          = beat_acc & s_axis.tlast;
  assign commit       = eof & ~discard_beat & ~i_frame_drop;

  // Write FSM next state and speculative/commit pointer updates
  always_comb begin
    state_d     = state_q;
    wr_spec_d   = wr_spec_q;
    wr_commit_d = wr_commit_q;
    drop_d      = 1'b0;
    if (wr_en) wr_spec_d = wr_spec_q + PTR_ONE;
    if (beat_acc) begin
      if (s_axis.tlast)             state_d = IDLE;
      else if (discard_beat)        state_d = DISCARD;
      else if (state_q == IDLE)     state_d = RECV;
    end
    if (eof) begin
      if (commit) begin
        wr_commit_d = wr_spec_q + PTR_ONE;
      end else begin
        wr_spec_d = wr_commit_q;
        drop_d    = 1'b1;
      end
    end
  end

  // Write FSM and write pointers; tready comes up one edge after reset release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wr_spec_q   <= '0;
      wr_commit_q <= '0;
      drop_q      <= 1'b0;
      s_tready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_spec_q   <= wr_spec_d;
      wr_commit_q <= wr_commit_d;
      drop_q      <= drop_d;
      s_tready_q  <= 1'b1;
    end
  end

  // Read pipeline: RAM stage feeds the output register; only fetch when the RAM stage can move
  assign out_load      = ~out_vld_q | m_axis.tready;
  assign rd_en         = (rd_ptr_q != wr_commit_q) & (~ram_vld_q | out_load);
  assign out_last_fire = out_vld_q & m_axis.tready & out_last_q;

  // Read pointer, pipeline valids, output beat and committed-frame count
  always_comb begin
    rd_ptr_d   = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    ram_vld_d  = rd_en | (ram_vld_q & ~out_load);
    out_vld_d  = out_vld_q;
    out_last_d = out_last_q;
    out_data_d = out_data_q;
    if (out_load) begin
      out_vld_d = ram_vld_q;
      if (ram_vld_q) {out_last_d, out_data_d} = ram_rdata;
    end
    pkt_cnt_d = pkt_cnt_q;
    case ({commit, out_last_fire})
      2'b10:   if (pkt_cnt_q != CNT_MAX) pkt_cnt_d = pkt_cnt_q + CNT_ONE;
      2'b01:   if (pkt_cnt_q != '0)      pkt_cnt_d = pkt_cnt_q - CNT_ONE;
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end

  // Read-side registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q   <= '0;
      ram_vld_q  <= 1'b0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_data_q <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      ram_vld_q  <= ram_vld_d;
      out_vld_q  <= out_vld_d;
      out_last_q <= out_last_d;
      out_data_q <= out_data_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  sdp_ram #(
    .WIDTH      (DATA_WIDTH + 1),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_spec_q[ADDR_WIDTH-1:0]),
    .wdata ({s_axis.tlast, s_axis.tdata}),
    .re    (rd_en),
    .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata (ram_rdata)
  );

`ifdef AXIS_PKT_FIFO_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of discarded frames
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_q && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  // Drop counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_cnt_q <= '0;
    else      drop_cnt_q <= drop_cnt_d;
  end

  assign o_drop_cnt = drop_cnt_q;
`else
  assign o_drop_cnt = 16'd0;
`endif

  // Words held counts beats already pulled into the read pipeline but not yet delivered
  assign o_wr_cnt      = used + PW'(ram_vld_q) + PW'(out_vld_q);
  assign o_pkt_cnt     = pkt_cnt_q;
  assign o_drop        = drop_q;
  assign s_axis.tready = s_tready_q;
  assign m_axis.tvalid = out_vld_q;
  assign m_axis.tlast  = out_last_q;
  assign m_axis.tdata  = out_data_q;

endmodule

// File: tb/tb_axis_packet_fifo.sv
// tb/tb_axis_packet_fifo.sv - self-checking bench for axis_packet_fifo (depth 16)
`timescale 1ns/1ps
module tb_axis_packet_fifo;
  import axis_pkt_fifo_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int PCW   = 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  axis_packet_fifo_if #(.DATA_WIDTH(DW)) s_if ();
  axis_packet_fifo_if #(.DATA_WIDTH(DW)) m_if ();

  logic           i_frame_drop;
  logic [AW:0]    o_wr_cnt;
  logic [PCW-1:0] o_pkt_cnt;
  logic           o_drop;
  logic [15:0]    o_drop_cnt;

  axis_packet_fifo #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .PKT_CNT_WIDTH (PCW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis       (s_if),
    .i_frame_drop (i_frame_drop),
    .m_axis       (m_if),
    .o_wr_cnt     (o_wr_cnt),
    .o_pkt_cnt    (o_pkt_cnt),
    .o_drop       (o_drop),
    .o_drop_cnt   (o_drop_cnt)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          exp_drops = 0;
  bit          rand_rdy = 1'b0;
  logic [15:0] seq = 16'h0;
  logic [DW:0] sb [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_dc();
`ifdef AXIS_PKT_FIFO_STATS_EN
    return exp_drops[15:0];
`else
    return 16'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) m_if.tready = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_beat(input logic last, input logic drop, input bit keep);
    logic [DW-1:0] d;
    d = {seq, 16'($urandom)};
    seq = seq + 16'd1;
    s_if.tdata   = d;
    s_if.tlast   = last;
    s_if.tvalid  = 1'b1;
    i_frame_drop = drop;
    if (keep) sb.push_back({last, d});
    tick();
  endtask

  task automatic send_frame(input int len, input logic drop, input bit keep);
    for (int i = 0; i < len; i++) begin
      if (rand_rdy && ($urandom_range(0, 3) == 0)) begin
        s_if.tvalid = 1'b0;
        tick();
      end
      drive_beat(i == len - 1, (i == len - 1) ? drop : 1'b0, keep);
    end
    s_if.tvalid  = 1'b0;
    s_if.tlast   = 1'b0;
    i_frame_drop = 1'b0;
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 2000;
    while (sb.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    check(tag, 64'(sb.size()), 64'd0);
  endtask

  // Output monitor: scoreboard compare on each handshake, stability while stalled
  logic [DW:0] prev_beat;
  bit          prev_stall = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      if (prev_stall) begin
        check("stall_tvalid", 64'(m_if.tvalid), 64'd1);
        check("stall_hold", 64'({m_if.tlast, m_if.tdata}), 64'(prev_beat));
      end
      if (m_if.tvalid && m_if.tready) begin
        if (sb.size() == 0) check("spurious_beat", 64'(m_if.tvalid), 64'd0);
        else check("out_beat", 64'({m_if.tlast, m_if.tdata}), 64'(sb.pop_front()));
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_beat  = {m_if.tlast, m_if.tdata};
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    s_if.tvalid  = 1'b0;
    s_if.tdata   = '0;
    s_if.tlast   = 1'b0;
    i_frame_drop = 1'b0;
    m_if.tready  = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_tready", 64'(s_if.tready), 64'd0);
    check("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
    check("rst_m_tlast", 64'(m_if.tlast), 64'd0);
    check("rst_m_tdata", 64'(m_if.tdata), 64'd0);
    check("rst_wr_cnt", 64'(o_wr_cnt), 64'd0);
    check("rst_pkt_cnt", 64'(o_pkt_cnt), 64'd0);
    check("rst_drop", 64'(o_drop), 64'd0);
    check("rst_drop_cnt", 64'(o_drop_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("tready_before_edge", 64'(s_if.tready), 64'd0);
    tick();
    check("tready_after_edge", 64'(s_if.tready), 64'd1);

    // 16-beat frame, exactly the depth, continuous tready
    send_frame(16, 1'b0, 1'b1);
    check("t1_pkt_cnt_commit", 64'(o_pkt_cnt), 64'd1);
    check("t1_tvalid_n0", 64'(m_if.tvalid), 64'd0);
    tick();
    check("t1_tvalid_n1", 64'(m_if.tvalid), 64'd0);
    tick();
    check("t1_tvalid_n2", 64'(m_if.tvalid), 64'd1);
    drain("t1_drain");
    tick(); tick();
    check("t1_pkt_cnt_done", 64'(o_pkt_cnt), 64'd0);
    check("t1_wr_cnt_done", 64'(o_wr_cnt), 64'd0);

    // 8-beat frame flagged for drop on tlast
    send_frame(8, 1'b1, 1'b0);
    exp_drops++;
    check("t2_drop_pulse", 64'(o_drop), 64'd1);
    check("t2_wr_cnt", 64'(o_wr_cnt), 64'd0);
    tick();
    check("t2_drop_end", 64'(o_drop), 64'd0);
    check("t2_drop_cnt", 64'(o_drop_cnt), 64'(exp_dc()));
    check("t2_no_out", 64'(m_if.tvalid), 64'd0);
    check("t2_pkt_cnt", 64'(o_pkt_cnt), 64'd0);

    // 20-beat frame overflows depth 16 and is dropped
    for (int i = 0; i < 20; i++) begin
      drive_beat(i == 19, 1'b0, 1'b0);
      if (i == 15) check("t3_wr_cnt_full", 64'(o_wr_cnt), 64'd16);
      if (i == 17) check("t3_wr_cnt_discard", 64'(o_wr_cnt), 64'd16);
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    exp_drops++;
    check("t3_drop_pulse", 64'(o_drop), 64'd1);
    check("t3_wr_cnt_rewind", 64'(o_wr_cnt), 64'd0);
    tick();
    check("t3_drop_cnt", 64'(o_drop_cnt), 64'(exp_dc()));
    send_frame(4, 1'b0, 1'b1);
    drain("t3_after_drain");

    // Three back-to-back 5-beat frames against a stalled output
    m_if.tready = 1'b0;
    send_frame(5, 1'b0, 1'b1);
    send_frame(5, 1'b0, 1'b1);
    send_frame(5, 1'b0, 1'b1);
    check("t4_pkt_cnt", 64'(o_pkt_cnt), 64'd3);
    check("t4_wr_cnt", 64'(o_wr_cnt), 64'd15);
    repeat (4) tick();
    check("t4_tvalid_stalled", 64'(m_if.tvalid), 64'd1);
    m_if.tready = 1'b1;
    drain("t4_drain");
    tick(); tick();
    check("t4_pkt_cnt_done", 64'(o_pkt_cnt), 64'd0);

    // Reset with a committed frame queued and another frame in flight
    m_if.tready = 1'b0;
    send_frame(3, 1'b0, 1'b1);
    drive_beat(1'b0, 1'b0, 1'b0);
    drive_beat(1'b0, 1'b0, 1'b0);
    s_if.tvalid = 1'b0;
    check("t5_pre_pkt_cnt", 64'(o_pkt_cnt), 64'd1);
    #2 rst = 1'b0;
    #1;
    sb.delete();
    exp_drops = 0;
    check("t5_s_tready", 64'(s_if.tready), 64'd0);
    check("t5_m_tvalid", 64'(m_if.tvalid), 64'd0);
    check("t5_m_tlast", 64'(m_if.tlast), 64'd0);
    check("t5_m_tdata", 64'(m_if.tdata), 64'd0);
    check("t5_wr_cnt", 64'(o_wr_cnt), 64'd0);
    check("t5_pkt_cnt", 64'(o_pkt_cnt), 64'd0);
    check("t5_drop", 64'(o_drop), 64'd0);
    check("t5_drop_cnt", 64'(o_drop_cnt), 64'd0);
    tick();
    check("t5_m_tvalid_held", 64'(m_if.tvalid), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    m_if.tready = 1'b1;
    send_frame(4, 1'b0, 1'b1);
    drain("t5_post_drain");

    // Random frames and tready across several pointer wraps
    rand_rdy = 1'b1;
    for (int f = 0; f < 30; f++) begin
      int   len;
      int   budget;
      logic drop;
      len    = $urandom_range(1, 8);
      drop   = ($urandom_range(0, 4) == 0);
      budget = 400;
      while ((sb.size() + len > DEPTH) && budget > 0) begin
        tick();
        budget--;
      end
      check("t6_fit_wait", 64'(budget > 0), 64'd1);
      send_frame(len, drop, !drop);
      if (drop) exp_drops++;
      check("t6_drop_pulse", 64'(o_drop), 64'(drop));
    end
    rand_rdy    = 1'b0;
    m_if.tready = 1'b1;
    drain("t6_drain");
    repeat (3) tick();
    check("end_pkt_cnt", 64'(o_pkt_cnt), 64'd0);
    check("end_wr_cnt", 64'(o_wr_cnt), 64'd0);
    check("end_drop_cnt", 64'(o_drop_cnt), 64'(exp_dc()));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
